// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-sliced ALU: opcode width and the opcode enum.
// Codes 3'b001 and 3'b111 are unused and produce a constant-zero result.
// Opcode bit 0 also selects ~B into the adder, so SUB = ADD with B inverted.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        HOLD_B = 3'b000,
        ADD    = 3'b010,
        SUB    = 3'b011,
        AND    = 3'b100,
        OR     = 3'b101,
        XOR    = 3'b110
    } alu_op_t;

endpackage : alu_pkg

// File: rtl/alu_slice_cell.sv
// -----------------------------------------------------------------------------
// alu_slice_cell
// Combinational 1-bit ALU slice. The adder always sees a + b' + carry_in where
// b' = ~b when op_select[0] is set, so the carry chain is live for every opcode.
// Logic ops and pass-B use the raw b, not b'.
// Ports:
//   a, b       in   operand bits
//   carry_in   in   carry from slice i-1 (or the array carry_in for slice 0)
//   op_select  in   opcode (alu_pkg::alu_op_t encoding)
//   result     out  selected result bit
//   carry_out  out  adder carry to slice i+1
// -----------------------------------------------------------------------------
module alu_slice_cell
    import alu_pkg::*;
(
    input  logic                a,
    input  logic                b,
    input  logic                carry_in,
    input  logic [ALU_OP_W-1:0] op_select,
    output logic                result,
    output logic                carry_out
);

    logic b_sel;
    logic sum;

    mux2_1_wide #(.WIDTH(1)) u_b_mux (
        .in0 (b),
        .in1 (~b),
        .sel (op_select[0]),
        .out (b_sel)
    );

    full_adder u_fa (
        .a         (a),
        .b         (b_sel),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // Index order matches the opcode map: unused codes 1 and 7 are tied to 0.
    mux8_1_wide #(.WIDTH(1)) u_res_mux (
        .in0 (b),
        .in1 (1'b0),
        .in2 (sum),
        .in3 (sum),
        .in4 (a & b),
        .in5 (a | b),
        .in6 (a ^ b),
        .in7 (1'b0),
        .sel (op_select),
        .out (result)
    );

endmodule : alu_slice_cell

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder leaf cell.
// Ports:
//   a, b      in   addend bits
//   carry_in  in   carry from the less significant slice
//   sum       out  a ^ b ^ carry_in
//   carry_out out  carry to the more significant slice
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic half_sum;

    assign half_sum  = a ^ b;
    assign sum       = half_sum ^ carry_in;
    assign carry_out = (a & b) | (carry_in & half_sum);

endmodule : full_adder

// File: rtl/mux2_1_wide.sv
// -----------------------------------------------------------------------------
// mux2_1_wide
// Parameterised 2:1 multiplexer leaf cell.
// Ports:
//   in0, in1  in   WIDTH data inputs
//   sel       in   1 selects in1, 0 selects in0
//   out       out  WIDTH selected data
// -----------------------------------------------------------------------------
module mux2_1_wide #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule : mux2_1_wide

// File: rtl/mux8_1_wide.sv
// -----------------------------------------------------------------------------
// mux8_1_wide
// Parameterised 8:1 multiplexer leaf cell.
// Ports:
//   in0..in7  in   WIDTH data inputs
//   sel       in   3-bit index
//   out       out  WIDTH selected data
// -----------------------------------------------------------------------------
module mux8_1_wide #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        // NOTE: default assignment first so no path through the block can infer a latch.
        out = '0;
        case (sel)
            3'd0:    out = in0;
            3'd1:    out = in1;
            3'd2:    out = in2;
            3'd3:    out = in3;
            3'd4:    out = in4;
            3'd5:    out = in5;
            3'd6:    out = in6;
            3'd7:    out = in7;
            default: out = '0;
        endcase
    end

endmodule : mux8_1_wide

// File: rtl/alu_slice_array.sv
// -----------------------------------------------------------------------------
// alu_slice_array
// Registered ripple-carry ALU built from WIDTH alu_slice_cell instances.
// Optional feature macro: ALU_FLAGS_EN adds registered zero/negative/overflow.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high; clears every register, beats en
//   en         in   1 = load new result this edge, 0 = hold
//   A, B       in   WIDTH operands
//   carry_in   in   carry into bit 0 (1 for two's-complement subtract)
//   op_select  in   opcode (alu_pkg::alu_op_t)
//   ALU_out    out  WIDTH registered result
//   zero       out  (ALU_FLAGS_EN) registered result == 0
//   negative   out  (ALU_FLAGS_EN) registered result MSB
//   overflow   out  (ALU_FLAGS_EN) registered signed overflow, ADD/SUB only
//   carry_out  out  registered MSB adder carry (never masked by opcode)
// -----------------------------------------------------------------------------
module alu_slice_array
    import alu_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic                carry_in,
    input  logic [ALU_OP_W-1:0] op_select,
    output logic [WIDTH-1:0]    ALU_out,
`ifdef ALU_FLAGS_EN
    output logic                zero,
    output logic                negative,
    output logic                overflow,
`endif
    output logic                carry_out
);

    // carry[i] feeds slice i; carry[WIDTH] leaves the MSB slice.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] result_next;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_slice_cell u_cell (
            .a         (A[i]),
            .b         (B[i]),
            .carry_in  (carry[i]),
            .op_select (op_select),
            .result    (result_next[i]),
            .carry_out (carry[i+1])
        );
    end

    // NOTE: the reset branch lives inside the clocked block, so it is synchronous
    // and takes priority over en.
    always_ff @(posedge clk) begin
        if (reset) begin
            ALU_out   <= '0;
            carry_out <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking assignments for all registered state.
            ALU_out   <= result_next;
            carry_out <= carry[WIDTH];
        end
    end

`ifdef ALU_FLAGS_EN
    logic is_arith;
    logic zero_next;
    logic negative_next;
    logic overflow_next;

    assign is_arith      = (op_select == ADD) || (op_select == SUB);
    assign zero_next     = (result_next == '0);
    assign negative_next = result_next[WIDTH-1];
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign overflow_next = is_arith & (carry[WIDTH] ^ carry[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (en) begin
            zero     <= zero_next;
            negative <= negative_next;
            overflow <= overflow_next;
        end
    end
`endif

endmodule : alu_slice_array

// File: tb/tb_alu_slice_array.sv
// -----------------------------------------------------------------------------
// tb_alu_slice_array
// Drives a WIDTH=1 and a WIDTH=8 instance in lockstep and compares both
// against an arithmetic reference model of the opcode table.
// -----------------------------------------------------------------------------
module tb_alu_slice_array;

    logic clk = 1'b0;
    logic reset;
    logic en;

    logic [0:0] a1, b1, out1;
    logic       cin1, cout1;
    logic [2:0] op1;

    logic [7:0] a8, b8, out8;
    logic       cin8, cout8;
    logic [2:0] op8;

`ifdef ALU_FLAGS_EN
    logic z1, n1, v1, z8, n8, v8;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Expected registered state: {overflow, negative, zero, carry_out, result[7:0]}
    logic [11:0] exp1, exp8;

    always #5 clk = ~clk;

    alu_slice_array #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .A         (a1),
        .B         (b1),
        .carry_in  (cin1),
        .op_select (op1),
        .ALU_out   (out1),
`ifdef ALU_FLAGS_EN
        .zero      (z1),
        .negative  (n1),
        .overflow  (v1),
`endif
        .carry_out (cout1)
    );

    alu_slice_array #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .A         (a8),
        .B         (b8),
        .carry_in  (cin8),
        .op_select (op8),
        .ALU_out   (out8),
`ifdef ALU_FLAGS_EN
        .zero      (z8),
        .negative  (n8),
        .overflow  (v8),
`endif
        .carry_out (cout8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: the opcode table evaluated with plain integer arithmetic.
    function automatic logic [11:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic [2:0] op);
        int unsigned mask, bp, s, res, msb;
        logic cout, zero, neg, ovf;
        mask = (1 << w) - 1;
        bp   = op[0] ? (~int'(b) & mask) : int'(b);
        s    = int'(a) + bp + int'(cin);
        cout = s[w];
        case (op)
            3'd0:       res = b;
            3'd2, 3'd3: res = s & mask;
            3'd4:       res = a & b;
            3'd5:       res = a | b;
            3'd6:       res = a ^ b;
            default:    res = 0;
        endcase
        res  = res & mask;
        msb  = w - 1;
        zero = (res == 0);
        neg  = res[msb];
        ovf  = (op == 3'd2 || op == 3'd3) && (a[msb] == bp[msb]) && (res[msb] != a[msb]);
        return {ovf, neg, zero, cout, res[7:0]};
    endfunction

    // Apply one clock edge, update the expected registers, and compare.
    task automatic step(input string tag);
        logic [11:0] m1, m8;
        m1 = model(1, {7'b0, a1}, {7'b0, b1}, cin1, op1);
        m8 = model(8, a8, b8, cin8, op8);
        @(posedge clk);
        #1;
        if (reset) begin
            exp1 = '0;
            exp8 = '0;
        end else if (en) begin
            exp1 = m1;
            exp8 = m8;
        end
        check({tag, " w1 out"},  {31'b0, out1}, {31'b0, exp1[0]});
        check({tag, " w1 cout"}, {31'b0, cout1}, {31'b0, exp1[8]});
        check({tag, " w8 out"},  {24'b0, out8}, {24'b0, exp8[7:0]});
        check({tag, " w8 cout"}, {31'b0, cout8}, {31'b0, exp8[8]});
`ifdef ALU_FLAGS_EN
        check({tag, " w1 flags"}, {29'b0, v1, n1, z1}, {29'b0, exp1[11:9]});
        check({tag, " w8 flags"}, {29'b0, v8, n8, z8}, {29'b0, exp8[11:9]});
`endif
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [2:0] op);
        a8 = a; b8 = b; cin8 = cin; op8 = op;
    endtask

    initial begin
        exp1 = '0;
        exp8 = '0;
        reset = 1'b1; en = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0; op1 = 3'd0;
        drive8(8'h00, 8'h00, 1'b0, 3'd0);
        step("init reset");

        // Nonzero result, then one reset edge with en still high.
        reset = 1'b0; en = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; op1 = 3'b010;
        drive8(8'h3C, 8'h41, 1'b1, 3'b010);
        step("load");
        check("load nonzero", {24'b0, out8}, 32'h7E);
        reset = 1'b1;
        step("reset wins");
        check("reset out zero", {24'b0, out8}, 32'h00);
        reset = 1'b0;

        // WIDTH=1: every opcode over every {A,B,carry_in}; WIDTH=8 gets random operands.
        for (int op = 0; op < 8; op++) begin
            for (int v = 0; v < 8; v++) begin
                a1 = v[2]; b1 = v[1]; cin1 = v[0]; op1 = op[2:0];
                drive8(8'($urandom), 8'($urandom), 1'($urandom), op[2:0]);
                step("exhaustive");
            end
        end

        // WIDTH=8 boundaries.
        drive8(8'hFF, 8'h01, 1'b0, 3'b010);
        step("add wrap");
        check("add wrap out", {24'b0, out8}, 32'h00);
        check("add wrap cout", {31'b0, cout8}, 32'h1);
        drive8(8'h05, 8'h07, 1'b1, 3'b011);
        step("sub a<b");
        check("sub a<b out", {24'b0, out8}, 32'hFE);
        check("sub a<b cout", {31'b0, cout8}, 32'h0);
`ifdef ALU_FLAGS_EN
        check("sub a<b neg", {31'b0, n8}, 32'h1);
`endif
        drive8(8'h9A, 8'h9A, 1'b1, 3'b011);
        step("sub a==b");
        check("sub a==b out", {24'b0, out8}, 32'h00);
        check("sub a==b cout", {31'b0, cout8}, 32'h1);
        drive8(8'h7F, 8'h01, 1'b0, 3'b010);
        step("add sovf");
        drive8(8'h80, 8'h01, 1'b1, 3'b011);
        step("sub sovf");
        drive8(8'hA5, 8'h5A, 1'b1, 3'b111);
        step("op111");
        check("op111 out", {24'b0, out8}, 32'h00);
        drive8(8'hA5, 8'h5A, 1'b0, 3'b001);
        step("op001");
        check("op001 out", {24'b0, out8}, 32'h00);

        // Load a known value, then hold through changing inputs.
        drive8(8'h12, 8'h34, 1'b0, 3'b010);
        step("pre-hold");
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); op1 = 3'($urandom);
            drive8(8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
            step("hold");
            check("hold out", {24'b0, out8}, 32'h46);
        end

        // Random traffic with en and occasional reset.
        for (int k = 0; k < 300; k++) begin
            en    = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 29) == 0);
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); op1 = 3'($urandom);
            drive8(8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_slice_array
